// File: rtl/pulse_meter_pkg.sv
// Shared types and constants for the pulse_meter block.
package pulse_meter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/pulse_sync.sv
// Input conditioning for pulse_meter: optional two-flop synchronizer (PULSE_METER_SYNC_EN),
// the sampled signal s, its delayed copy and the rise/fall strobes.
module pulse_sync (
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    output logic s,
    output logic rise,
    output logic fall,
    output logic ready
);

    logic s_d;
    logic s_next;

`ifdef PULSE_METER_SYNC_EN
    logic [1:0] meta;
    logic [2:0] prime;

    // ready marks the first cycle in which s reflects a genuinely sampled pulse_in after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= '0;
            prime <= '0;
        end else begin
            meta  <= {meta[0], pulse_in};
            prime <= {prime[1:0], 1'b1};
        end
    end

    assign s_next = meta[1];
    assign ready  = prime[2];
`else
    logic prime;

    always_ff @(posedge clk) begin
        if (rst) begin
            prime <= 1'b0;
        end else begin
            prime <= 1'b1;
        end
    end

    assign s_next = pulse_in;
    assign ready  = prime;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s   <= 1'b0;
            s_d <= 1'b0;
        end else begin
            s   <= s_next;
            s_d <= s;
        end
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

// File: rtl/pulse_meter.sv
// Measures the high time of pulse_in in clk cycles and hands it over with a valid/ack handshake.
// Define PULSE_METER_SYNC_EN to add a two-flop synchronizer in front of the sampler.
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             ack,
    output logic [WIDTH-1:0] width,
    output logic             valid,
    output logic             ovf,
    output logic             missed
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_next;
    logic             s;
    logic             rise;
    logic             fall;
    logic             ready;
    logic [WIDTH-1:0] cnt;
    logic             cnt_ovf;

    pulse_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (pulse_in),
        .s        (s),
        .rise     (rise),
        .fall     (fall),
        .ready    (ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARM;
        end else begin
            state <= state_next;
        end
    end

    // ARM only releases once s is trustworthy and low, so a pulse already high is never caught mid-way.
    always_comb begin
        state_next = state;
        case (state)
            ARM:     if (ready && !s) state_next = IDLE;
            IDLE:    if (rise)        state_next = MEAS;
            MEAS:    if (fall)        state_next = DONE;
            DONE:    if (valid && ack) state_next = ARM;
            default:                  state_next = ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            cnt_ovf <= 1'b0;
            width   <= '0;
            ovf     <= 1'b0;
            valid   <= 1'b0;
            missed  <= 1'b0;
        end else begin
            if (state == IDLE && rise) begin
                cnt     <= WIDTH'(1);
                cnt_ovf <= 1'b0;
            end else if (state == MEAS && s) begin
                if (cnt == CNT_MAX) begin
                    cnt_ovf <= 1'b1;
                end else begin
                    cnt <= cnt + WIDTH'(1);
                end
            end

            if (state == MEAS && fall) begin
                width <= cnt;
                ovf   <= cnt_ovf;
                valid <= 1'b1;
            end else if (state == DONE && valid && ack) begin
                valid <= 1'b0;
            end

            if (state == DONE && rise) begin
                missed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
// Directed self-checking bench for pulse_meter (WIDTH=8 and WIDTH=4 instances share stimulus).
module tb_pulse_meter;

`ifdef PULSE_METER_SYNC_EN
    localparam int LATENCY = 9;
`else
    localparam int LATENCY = 7;
`endif

    logic       clk;
    logic       rst;
    logic       pulse_in;
    logic       ack;
    logic [7:0] w8;
    logic       v8, o8, m8;
    logic [3:0] w4;
    logic       v4, o4, m4;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int valid_count8 = 0;
    int valid_count4 = 0;
    int first_valid8 = -1;
    int start_cyc = 0;

    pulse_meter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .ack(ack),
        .width(w8), .valid(v8), .ovf(o8), .missed(m8)
    );

    pulse_meter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .ack(ack),
        .width(w4), .valid(v4), .ovf(o4), .missed(m4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v8) begin
            valid_count8++;
            if (first_valid8 < 0) first_valid8 = cyc;
        end
        if (v4) valid_count4++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int high_cycles, input int low_cycles);
        pulse_in = 1'b1;
        repeat (high_cycles) tick();
        pulse_in = 1'b0;
        repeat (low_cycles) tick();
        @(negedge clk);
    endtask

    task automatic ackResult();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
    endtask

    task automatic clearMonitor();
        valid_count8 = 0;
        valid_count4 = 0;
        first_valid8 = -1;
    endtask

    initial begin
        rst = 1'b1;
        pulse_in = 1'b0;
        ack = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checkOutput("reset_valid", 32'(v8), 32'd0);
        checkOutput("reset_width", 32'(w8), 32'd0);
        checkOutput("reset_ovf", 32'(o8), 32'd0);
        checkOutput("reset_missed", 32'(m8), 32'd0);
        tick();
        rst = 1'b0;
        repeat (4) tick();

        // 5-cycle pulse with ack held high: one-cycle valid at a fixed latency
        ack = 1'b1;
        clearMonitor();
        start_cyc = cyc;
        applyStimulus(5, 12);
        checkOutput("p5_width", 32'(w8), 32'd5);
        checkOutput("p5_ovf", 32'(o8), 32'd0);
        checkOutput("p5_valid_cycles", 32'(valid_count8), 32'd1);
        checkOutput("p5_latency", 32'(first_valid8 - start_cyc), 32'(LATENCY));
        checkOutput("p5_valid_low", 32'(v8), 32'd0);
        checkOutput("p5_w4_width", 32'(w4), 32'd5);
        checkOutput("p5_w4_valid_cycles", 32'(valid_count4), 32'd1);
        ack = 1'b0;
        tick();

        // 20-cycle pulse: saturates the 4-bit meter, fits the 8-bit one
        applyStimulus(20, 8);
        checkOutput("p20_w4_width", 32'(w4), 32'd15);
        checkOutput("p20_w4_ovf", 32'(o4), 32'd1);
        checkOutput("p20_w4_valid", 32'(v4), 32'd1);
        checkOutput("p20_w8_width", 32'(w8), 32'd20);
        checkOutput("p20_w8_ovf", 32'(o8), 32'd0);
        repeat (3) tick();
        @(negedge clk);
        checkOutput("p20_hold_width", 32'(w4), 32'd15);
        checkOutput("p20_hold_valid", 32'(v4), 32'd1);
        ackResult();
        @(negedge clk);
        checkOutput("p20_acked_valid", 32'(v4), 32'd0);
        applyStimulus(3, 8);
        checkOutput("p3_w4_width", 32'(w4), 32'd3);
        checkOutput("p3_w4_ovf", 32'(o4), 32'd0);
        checkOutput("p3_w4_valid", 32'(v4), 32'd1);
        ackResult();

        // Second pulse during DONE is missed; third pulse measured after ack
        checkOutput("miss_pre", 32'(m8), 32'd0);
        applyStimulus(3, 6);
        checkOutput("miss_first_width", 32'(w8), 32'd3);
        applyStimulus(2, 6);
        checkOutput("miss_flag", 32'(m8), 32'd1);
        checkOutput("miss_width_held", 32'(w8), 32'd3);
        checkOutput("miss_valid_held", 32'(v8), 32'd1);
        ackResult();
        applyStimulus(4, 8);
        checkOutput("miss_third_width", 32'(w8), 32'd4);
        checkOutput("miss_third_valid", 32'(v8), 32'd1);
        checkOutput("miss_sticky", 32'(m8), 32'd1);
        ackResult();

        // Reset on the 3rd high cycle of a 6-cycle pulse discards it
        clearMonitor();
        pulse_in = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        pulse_in = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        checkOutput("rst_mid_no_valid", 32'(valid_count8), 32'd0);
        checkOutput("rst_mid_missed_clr", 32'(m8), 32'd0);
        applyStimulus(2, 8);
        checkOutput("rst_mid_next_width", 32'(w8), 32'd2);
        checkOutput("rst_mid_next_valid", 32'(v8), 32'd1);
        ackResult();

        // Pulse already high across reset release is ignored
        clearMonitor();
        pulse_in = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        pulse_in = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        checkOutput("rst_high_no_valid", 32'(valid_count8), 32'd0);
        applyStimulus(1, 8);
        checkOutput("p1_width", 32'(w8), 32'd1);
        checkOutput("p1_ovf", 32'(o8), 32'd0);
        checkOutput("p1_valid", 32'(v8), 32'd1);
        ackResult();
        @(negedge clk);
        checkOutput("p1_acked", 32'(v8), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_meter.md
PULSE_METER -- requirements
Module: pulse_meter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bit width of the measured pulse length.
REQ-002 clk  input  1  SHALL be the single clock; all logic samples on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 pulse_in  input  1  SHALL carry the asynchronous pulse to be measured, e.g. a pulse generator output.
REQ-005 ack  input  1  SHALL be the consumer acknowledge for the current result.
REQ-006 width  output  WIDTH  SHALL give the measured high time in clk cycles.
REQ-007 valid  output  1  SHALL be high while width/ovf hold a result not yet acknowledged.
REQ-008 ovf  output  1  SHALL flag that the count saturated during the reported pulse.
REQ-009 missed  output  1  SHALL be a sticky flag for a rising edge seen while a result was pending.

Function
REQ-010 The block SHALL register pulse_in into a sampled signal s, and keep s_d (s delayed one cycle) for edge detection; rise = s & ~s_d, fall = ~s & s_d.
REQ-011 The FSM SHALL have the states ARM, IDLE, MEAS and DONE.
- ARM: wait for s=0, then go to IDLE.
- IDLE: on rise go to MEAS with cnt=1.
- MEAS: while s=1, cnt increments; on fall go to DONE.
- DONE: wait for ack.
REQ-012 A 1-cycle-high s SHALL yield width=1; in general width SHALL equal the number of consecutive cycles s was 1.
REQ-013 Count SHALL saturate at 2^WIDTH-1 and set ovf; it SHALL never wrap.
REQ-014 On entry to DONE, width and ovf SHALL be loaded, and valid SHALL rise in the cycle after fall is detected.
REQ-015 width, ovf and valid SHALL stay stable while valid=1 and ack=0.
REQ-016 ack=1 in a cycle with valid=1 SHALL clear valid on the next edge and return the FSM to ARM.
- ack with valid=0 SHALL be ignored.
REQ-017 ack asserted in the same cycle valid first rises SHALL be honoured, so valid is high for exactly one cycle.
REQ-018 A rise detected in DONE SHALL set missed, and that pulse SHALL NOT be measured.
- missed SHALL clear only on rst.
REQ-019 Returning through ARM SHALL ensure that a pulse already high on exit from DONE is not measured from mid-pulse.
REQ-020 If pulse_in is still 1 at the end of reset, the FSM SHALL stay in ARM until s=0.

Reset
REQ-021 When rst=1 at a clock edge: FSM SHALL go to ARM; width, ovf, valid and missed SHALL be 0; cnt, s and s_d SHALL be 0.
REQ-022 Reset mid-MEAS or mid-DONE SHALL discard the partial or pending result with no valid pulse.

Configuration
REQ-023 Macro PULSE_METER_SYNC_EN, when defined, SHALL insert a two-flop synchronizer ahead of the s register, adding 2 cycles of latency from pulse_in to valid.
- Measured width SHALL be unchanged.
REQ-024 Without PULSE_METER_SYNC_EN, only the single s register SHALL be present, for pulse_in already synchronous to clk.

Structure
REQ-025 Package pulse_meter_pkg SHALL hold the FSM state enum (ARM, IDLE, MEAS, DONE) and the constant for the default WIDTH.
REQ-026 Sub-module pulse_sync SHALL contain the optional synchronizer, the s/s_d registers and the rise/fall outputs.
- The FSM, counter and handshake SHALL live in pulse_meter.

Verification
REQ-027 Scenario: 5-cycle pulse, idle before, ack held 1 -> width=5, ovf=0, valid high for exactly 1 cycle.
REQ-028 Scenario: WIDTH=4 and a 20-cycle pulse -> width=15, ovf=1; a following 3-cycle pulse after ack -> width=3, ovf=0.
REQ-029 Scenario: ack held 0 and a second 2-cycle pulse during DONE -> missed=1, width still holds the first value; after ack, a third pulse of 4 cycles -> width=4.
REQ-030 Scenario: rst asserted on the 3rd high cycle of a 6-cycle pulse -> no valid; the next 2-cycle pulse -> width=2.
REQ-031 Scenario: pulse_in high through reset release for 4 cycles -> no valid; the next 1-cycle pulse -> width=1.
REQ-032 Scenario: the 5-cycle pulse case run with and without PULSE_METER_SYNC_EN -> identical width, and valid delayed by exactly 2 cycles when the macro is defined.
